// File: rtl/load_store_unit.sv
// Memory stage of the RV32I pipeline: ALU pass-through, byte-lane aligned stores and
// sign/zero-extended loads over a req/gnt/rvalid bus. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        flush_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_write_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  wb_rd_o,
  output logic        wb_reg_write_o,
  output logic        bus_err_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = a[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        idle_go, mem_op, misal, accept, pass;
  logic        store_done, load_done, timeout;

  logic [31:0] addr_p1, wdata_p1;
  logic [3:0]  wstrb_p1;
  logic [1:0]  off_p1;
  logic [2:0]  f3_p1;
  logic [4:0]  rd_p1;
  logic        we_p1, regw_p1;
  logic [7:0]  cnt_p1;

  logic        vld_p2, regw_p2, bus_err_p2;
  logic [31:0] wb_data_p2;
  logic [4:0]  wb_rd_p2;

  assign mem_op  = mem_read_i | mem_write_i;
  // Reset gates accept so stall_o falls with rst_n even while EX still presents work.
  assign idle_go = rst_n & (state_q == IDLE) & ex_valid_i & ~flush_i;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misal   = ((funct3_i[1:0] == 2'b01) && alu_data_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (alu_data_i[1:0] != 2'b00));
`else
  assign misal   = 1'b0;
`endif
  assign accept  = idle_go & mem_op & ~misal;
  assign pass    = idle_go & ~mem_op;

  assign store_done = (state_q == REQ) & dmem_gnt_i & we_p1;
  assign load_done  = (state_q == RESP) & dmem_rvalid_i;
  assign timeout    = ((state_q == REQ) | (state_q == RESP)) & (cnt_p1 == TO_LAST) &
                      ~store_done & ~load_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (store_done)      state_d = IDLE;
        else if (timeout)    state_d = IDLE;
        else if (dmem_gnt_i) state_d = RESP;
      end
      RESP: if (load_done || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_req_o = 1'b0;
    stall_o    = accept;
    case (state_q)
      REQ: begin
        dmem_req_o = 1'b1;
        stall_o    = ~store_done & ~timeout;
      end
      RESP:    stall_o = ~load_done & ~timeout;
      default: ;
    endcase
  end

  // EX -> MEM: capture the accepted access and hold it stable until the bus takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      wstrb_p1 <= '0;
      off_p1   <= '0;
      f3_p1    <= '0;
      rd_p1    <= '0;
      we_p1    <= 1'b0;
      regw_p1  <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      if (accept) begin
        addr_p1  <= {alu_data_i[31:2], 2'b00};
        off_p1   <= alu_data_i[1:0];
        wdata_p1 <= lane_wdata(funct3_i[1:0], rs2_data_i);
        wstrb_p1 <= lane_strb(funct3_i[1:0], alu_data_i[1:0]);
        f3_p1    <= funct3_i;
        rd_p1    <= rd_i;
        we_p1    <= mem_write_i;
        regw_p1  <= reg_write_i;
        cnt_p1   <= '0;
      end else if (state_q != IDLE) begin
        cnt_p1   <= cnt_p1 + 8'd1;
      end
    end
  end

  // MEM -> WB: one-cycle writeback and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2     <= 1'b0;
      wb_data_p2 <= '0;
      wb_rd_p2   <= '0;
      regw_p2    <= 1'b0;
      bus_err_p2 <= 1'b0;
    end else begin
      vld_p2     <= 1'b0;
      bus_err_p2 <= timeout;
      if (pass) begin
        vld_p2     <= 1'b1;
        wb_data_p2 <= alu_data_i;
        wb_rd_p2   <= rd_i;
        regw_p2    <= reg_write_i;
      end else if (store_done) begin
        vld_p2     <= 1'b1;
        wb_data_p2 <= '0;
        wb_rd_p2   <= rd_p1;
        regw_p2    <= 1'b0;
      end else if (load_done) begin
        vld_p2     <= 1'b1;
        wb_data_p2 <= load_extend(f3_p1, off_p1, dmem_rdata_i);
        wb_rd_p2   <= rd_p1;
        regw_p2    <= regw_p1;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_p2 <= 1'b0;
    else        misalign_p2 <= idle_go & mem_op & misal;
  end

  assign misalign_o = misalign_p2;
`endif

  assign dmem_we_o      = we_p1;
  assign dmem_addr_o    = addr_p1;
  assign dmem_wdata_o   = wdata_p1;
  assign dmem_wstrb_o   = wstrb_p1;
  assign wb_valid_o     = vld_p2;
  assign wb_data_o      = wb_data_p2;
  assign wb_rd_o        = wb_rd_p2;
  assign wb_reg_write_o = regw_p2;
  assign bus_err_o      = bus_err_p2;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expected writebacks,
// a negedge monitor pops and compares them. A second instance runs with BUS_TIMEOUT=4.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n, rst_to;
  logic        ex_valid_i, flush_i, mem_read_i, mem_write_i, reg_write_i;
  logic [31:0] alu_data_i, rs2_data_i, dmem_rdata_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        dmem_gnt_i, dmem_rvalid_i;

  logic        stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_reg_write_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_wstrb_o;
  logic [4:0]  wb_rd_o;

  logic        stall_to, req_to, we_to, wb_valid_to, wb_regw_to, bus_err_to;
  logic [31:0] addr_to, wdata_to, wb_data_to;
  logic [3:0]  wstrb_to;
  logic [4:0]  wb_rd_to;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o, misalign_to;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic        chk_data;
  } wb_t;
  wb_t exp_q[$];
  wb_t mon_e;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .alu_data_i(alu_data_i), .rs2_data_i(rs2_data_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
    .wb_reg_write_o(wb_reg_write_o), .bus_err_o(bus_err_o)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  load_store_unit #(.BUS_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_to), .ex_valid_i(ex_valid_i), .flush_i(flush_i),
    .alu_data_i(alu_data_i), .rs2_data_i(rs2_data_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
    .stall_o(stall_to), .dmem_req_o(req_to), .dmem_we_o(we_to),
    .dmem_addr_o(addr_to), .dmem_wdata_o(wdata_to), .dmem_wstrb_o(wstrb_to),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_to), .wb_data_o(wb_data_to), .wb_rd_o(wb_rd_to),
    .wb_reg_write_o(wb_regw_to), .bus_err_o(bus_err_to)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(misalign_to)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wb(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                           input logic cd);
    wb_t e;
    e.data = d; e.rd = rd; e.regw = rw; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic rw);
    ex_valid_i = 1'b1; flush_i = 1'b0; mem_read_i = rd_op; mem_write_i = wr_op;
    funct3_i = f3; alu_data_i = a; rs2_data_i = d; rd_i = rd; reg_write_i = rw;
  endtask

  task automatic idle_in();
    ex_valid_i = 1'b0; flush_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wdata, input string nm);
    issue(1'b0, 1'b1, f3, a, d, 5'd0, 1'b0);
    expect_wb(32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk({nm, "_acc_stall"}, 32'(stall_o), 32'd1);
    chk({nm, "_acc_req"}, 32'(dmem_req_o), 32'd0);
    to_next();
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk({nm, "_req"}, 32'(dmem_req_o), 32'd1);
    chk({nm, "_addr"}, dmem_addr_o, e_addr);
    chk({nm, "_wstrb"}, 32'(dmem_wstrb_o), 32'(e_strb));
    chk({nm, "_wdata"}, dmem_wdata_o, e_wdata);
    chk({nm, "_we"}, 32'(dmem_we_o), 32'd1);
    chk({nm, "_gnt_stall"}, 32'(stall_o), 32'd0);
    to_next();
    dmem_gnt_i = 1'b0;
    idle_in();
    @(negedge clk);
    chk({nm, "_lat"}, 32'(wb_valid_o), 32'd1);
    to_next();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                         input logic [4:0] rd, input logic [31:0] e_data, input string nm);
    issue(1'b1, 1'b0, f3, a, 32'd0, rd, 1'b1);
    expect_wb(e_data, rd, 1'b1, 1'b1);
    to_next();
    dmem_gnt_i = 1'b1;
    to_next();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = word;
    @(negedge clk);
    chk({nm, "_stall"}, 32'(stall_o), 32'd0);
    to_next();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    idle_in();
    @(negedge clk);
    chk({nm, "_lat"}, 32'(wb_valid_o), 32'd1);
    to_next();
  endtask

  // Writeback monitor
  initial begin
    forever begin
      @(negedge clk);
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.chk_data) begin
            chk("wb_data", wb_data_o, mon_e.data);
            chk("wb_rd", 32'(wb_rd_o), 32'(mon_e.rd));
          end
          chk("wb_regw", 32'(wb_reg_write_o), 32'(mon_e.regw));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst_to = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0000_FFFF, 5'd3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wstrb", 32'(dmem_wstrb_o), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_to_outs", 32'(|{stall_to, req_to, we_to, addr_to, wdata_to, wstrb_to, wb_valid_to,
                             wb_data_to, wb_rd_to, wb_regw_to, bus_err_to}), 32'd0);
    idle_in();
    @(posedge clk);
    #1 rst_n = 1'b1;
    to_next();

    // ALU pass-through
    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd5, 1'b1);
    expect_wb(32'h1234_5678, 5'd5, 1'b1, 1'b1);
    @(negedge clk);
    chk("pt_stall", 32'(stall_o), 32'd0);
    to_next();
    idle_in();
    @(negedge clk);
    chk("pt_lat", 32'(wb_valid_o), 32'd1);
    chk("pt_stall2", 32'(stall_o), 32'd0);
    to_next();

    // Stores: byte, half, word
    do_store(3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, "sb");
    do_store(3'b001, 32'h0000_1002, 32'h1234_CDEF, 32'h0000_1000, 4'b1100, 32'hCDEF_CDEF, "sh");
    do_store(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, "sw");

    // LB with late gnt, stray rvalid in REQ, rvalid 3 cycles after gnt
    issue(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, 5'd7, 1'b1);
    expect_wb(32'hFFFF_FF80, 5'd7, 1'b1, 1'b1);
    @(negedge clk);
    chk("lb_acc_stall", 32'(stall_o), 32'd1);
    to_next();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_0000;
    @(negedge clk);
    chk("lb_req", 32'(dmem_req_o), 32'd1);
    chk("lb_addr", dmem_addr_o, 32'h0000_2000);
    chk("lb_we", 32'(dmem_we_o), 32'd0);
    chk("lb_stall_req", 32'(stall_o), 32'd1);
    to_next();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0; dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("lb_stall_gnt", 32'(stall_o), 32'd1);
    to_next();
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("lb_resp_req", 32'(dmem_req_o), 32'd0);
    chk("lb_stall_r1", 32'(stall_o), 32'd1);
    to_next();
    @(negedge clk);
    chk("lb_stall_r2", 32'(stall_o), 32'd1);
    to_next();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0080_0000;
    @(negedge clk);
    chk("lb_stall_rv", 32'(stall_o), 32'd0);
    to_next();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    idle_in();
    @(negedge clk);
    chk("lb_lat", 32'(wb_valid_o), 32'd1);
    chk("lb_stall_after", 32'(stall_o), 32'd0);
    to_next();

    // Other loads at minimum latency
    do_load(3'b101, 32'h0000_2002, 32'h8001_0000, 5'd9,  32'h0000_8001, "lhu");
    do_load(3'b001, 32'h0000_2000, 32'h1234_F00F, 5'd10, 32'hFFFF_F00F, "lh");
    do_load(3'b100, 32'h0000_2003, 32'h9A00_0000, 5'd11, 32'h0000_009A, "lbu");
    do_load(3'b010, 32'h0000_2004, 32'hCAFE_F00D, 5'd12, 32'hCAFE_F00D, "lw");

    // Flush: neither a writeback nor an access, and gnt in IDLE is ignored
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'd0, 5'd4, 1'b1);
    flush_i = 1'b1; dmem_gnt_i = 1'b1;
    @(negedge clk);
    chk("fl_alu_stall", 32'(stall_o), 32'd0);
    to_next();
    issue(1'b0, 1'b1, 3'b010, 32'h0000_1008, 32'h1111_2222, 5'd0, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    chk("fl_alu_wb", 32'(wb_valid_o), 32'd0);
    chk("fl_st_stall", 32'(stall_o), 32'd0);
    to_next();
    idle_in(); dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("fl_st_req", 32'(dmem_req_o), 32'd0);
    chk("fl_st_wb", 32'(wb_valid_o), 32'd0);
    to_next();

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 5'd13, 1'b1);
    @(negedge clk);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_req0", 32'(dmem_req_o), 32'd0);
    to_next();
    idle_in();
    @(negedge clk);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    chk("mis_wb", 32'(wb_valid_o), 32'd0);
    chk("mis_req1", 32'(dmem_req_o), 32'd0);
    to_next();
    @(negedge clk);
    chk("mis_pulse_end", 32'(misalign_o), 32'd0);
    to_next();
`else
    do_load(3'b001, 32'h0000_2003, 32'h8000_0000, 5'd13, 32'hFFFF_8000, "lh_odd");
`endif

    // Reset asserted mid-RESP
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'd0, 5'd14, 1'b1);
    to_next();
    dmem_gnt_i = 1'b1;
    to_next();
    dmem_gnt_i = 1'b0;
    @(negedge clk);
    chk("rr_stall_pre", 32'(stall_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rr_stall", 32'(stall_o), 32'd0);
    chk("rr_req", 32'(dmem_req_o), 32'd0);
    chk("rr_addr", dmem_addr_o, 32'd0);
    chk("rr_wstrb", 32'(dmem_wstrb_o), 32'd0);
    chk("rr_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rr_wb_data", wb_data_o, 32'd0);
    idle_in();
    to_next();

    // Timeout on the BUS_TIMEOUT=4 instance, gnt held low
    rst_to = 1'b1;
    to_next();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 5'd15, 1'b1);
    @(negedge clk);
    chk("to_acc_stall", 32'(stall_to), 32'd1);
    to_next();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("to_stall", 32'(stall_to), 32'd1);
      chk("to_err_early", 32'(bus_err_to), 32'd0);
      to_next();
    end
    @(negedge clk);
    chk("to_last_stall", 32'(stall_to), 32'd0);
    chk("to_last_req", 32'(req_to), 32'd1);
    to_next();
    idle_in();
    @(negedge clk);
    chk("to_err", 32'(bus_err_to), 32'd1);
    chk("to_wb", 32'(wb_valid_to), 32'd0);
    chk("to_idle_req", 32'(req_to), 32'd0);
    to_next();
    @(negedge clk);
    chk("to_err_end", 32'(bus_err_to), 32'd0);
    chk("to_idle_stall", 32'(stall_to), 32'd0);
    to_next();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
